// File: rtl/mp_alu_seq_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: ALU op codes,
// op-class predicates and the sequencer state encoding.
package mp_alu_seq_pkg;

    // Op codes of the external 8-bit combinational ALU.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SBB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ops whose ALU carry-out is meaningful (ADD, ADC, SBB).
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op <= OP_SBB);
    endfunction

    // Ops that consume the command's carry/borrow-in on the first byte.
    function automatic logic op_takes_ci(input logic [2:0] op);
        return (op == OP_ADC) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: walks an NBYTES-wide command through an external
// 8-bit ALU one byte per cycle (LSB first), chaining carry/borrow, then
// returns the assembled result with carry and zero flags.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The requester holds valid and payload stable until that
// edge; the block holds rsp_valid and rsp_* stable until rsp_ready is seen.
module mp_alu_seq
    import mp_alu_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_ci,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_co,
    output logic         rsp_zero,
    output logic [2:0]   alu_op,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_ci,
    input  logic [7:0]   alu_result,
    input  logic         alu_co
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
    localparam logic [W-1:0]  LANE_MASK = W'(8'hFF);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           first_ci_q, first_ci_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;

    // Bit offset of the current byte lane, and operands shifted down to it.
    logic [IW+2:0]  lane_sh;
    logic [W-1:0]   a_shift;
    logic [W-1:0]   b_shift;

    // Response outputs come straight from registers so they stay stable in DONE.
    assign rsp_result = result_q;
    assign rsp_co     = carry_q;
    assign rsp_zero   = zero_q;

    // Lane select: move byte idx of each operand into bits [7:0].
    always_comb begin
        lane_sh = {idx_q, 3'b000};
        a_shift = a_q >> lane_sh;
        b_shift = b_q >> lane_sh;
    end

    // Next-state, datapath update and handshake/ALU outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        first_ci_d = first_ci_q;
        carry_d    = carry_q;
        result_d   = result_q;
        zero_d     = zero_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_op     = OP_CLR;
        alu_a      = 8'd0;
        alu_b      = 8'd0;
        alu_ci     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    first_ci_d = op_takes_ci(cmd_op) ? cmd_ci : 1'b0;
                    carry_d    = 1'b0;
                    result_d   = '0;
                    idx_d      = '0;
                    state_d    = ST_RUN;
                end
            end

            ST_RUN: begin
                alu_a  = a_shift[7:0];
                alu_b  = b_shift[7:0];
                alu_ci = (idx_q == '0) ? first_ci_q : carry_q;
                // Upper bytes of a plain ADD must add in the chained carry.
                alu_op = ((op_q == OP_ADD) && (idx_q != '0)) ? OP_ADC : op_q;

                result_d = (result_q & ~(LANE_MASK << lane_sh))
                         | (W'(alu_result) << lane_sh);
                // Logic ops leave the ALU carry stale, so never sample it.
                carry_d  = op_is_arith(op_q) ? alu_co : 1'b0;

                if (idx_q == IDX_LAST) begin
                    zero_d  = (result_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset discards any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            first_ci_q <= 1'b0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            first_ci_q <= first_ci_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq: directed commands with hand-computed results, a
// byte-level ALU model on the alu_* port, a full-width reference model, and a
// compare process that checks every presented response against the queue.
module tb_mp_alu_seq;

    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         cmd_ci = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         rsp_co;
    logic         rsp_zero;
    logic [2:0]   alu_op;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_ci;
    logic [7:0]   alu_result;
    logic         alu_co;

    mp_alu_seq #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_ci     (cmd_ci),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_co     (rsp_co),
        .rsp_zero   (rsp_zero),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ci     (alu_ci),
        .alu_result (alu_result),
        .alu_co     (alu_co)
    );

    // ---------------- external 8-bit ALU ----------------
    // Logic ops drive co=1 on purpose: a stale carry the sequencer must ignore.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum    = 9'd0;
        alu_result = 8'd0;
        alu_co     = 1'b1;
        case (alu_op)
            3'd0: begin alu_sum = {1'b0, alu_a} + {1'b0, alu_b};                  alu_result = alu_sum[7:0]; alu_co = alu_sum[8]; end
            3'd1: begin alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci}; alu_result = alu_sum[7:0]; alu_co = alu_sum[8]; end
            3'd2: begin alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_ci}; alu_result = alu_sum[7:0]; alu_co = alu_sum[8]; end
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a ^ alu_b;
            3'd6: alu_result = ~alu_a;
            default: alu_result = 8'd0;
        endcase
    end

    // ---------------- full-width reference model ----------------
    function automatic logic [W:0] model_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic ci);
        logic [W:0] r;
        case (op)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            3'd2: r = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
            3'd3: r = {1'b0, a & b};
            3'd4: r = {1'b0, a | b};
            3'd5: r = {1'b0, a ^ b};
            3'd6: r = {1'b0, ~a};
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_co_q[$];
    logic         exp_zero_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare every presented response against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                check("rsp_result", rsp_result, exp_q[0]);
                check("rsp_co", rsp_co, exp_co_q[0]);
                check("rsp_zero", rsp_zero, exp_zero_q[0]);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_co_q.pop_front());
                    void'(exp_zero_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a command right after a rising edge; pin the model to the literal.
    task automatic drive_cmd(input string name, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic ci,
                             input logic [W-1:0] hand_res, input logic hand_co);
        @(posedge clk);
        #1;
        check({name, "_model"}, model_op(op, a, b, ci), {hand_co, hand_res});
        exp_q.push_back(hand_res);
        exp_co_q.push_back(hand_co);
        exp_zero_q.push_back(hand_res == '0);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_ci    = ci;
        cmd_valid = 1'b1;
    endtask

    // Wait (bounded) for cmd_ready; the accept is the following rising edge.
    task automatic wait_accept(input string name, output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (cmd_ready) break;
        end
        if (!cmd_ready) check({name, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Check the per-byte ALU drive and the response latency after the accept.
    task automatic run_body(input string name, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic ci);
        logic [W-1:0] sa, sb;
        for (int i = 0; i < NBYTES; i++) begin
            @(negedge clk);
            sa = a >> (8 * i);
            sb = b >> (8 * i);
            check({name, "_alu_op"}, alu_op, ((op == 3'd0) && (i > 0)) ? 3'd1 : op);
            check({name, "_alu_a"}, alu_a, sa[7:0]);
            check({name, "_alu_b"}, alu_b, sb[7:0]);
            check({name, "_rsp_valid_early"}, rsp_valid, 0);
            if (i == 0) check({name, "_alu_ci0"}, alu_ci, ((op == 3'd1) || (op == 3'd2)) ? ci : 1'b0);
        end
        @(negedge clk);
        check({name, "_rsp_valid_latency"}, rsp_valid, 1);
        check({name, "_alu_op_idle"}, alu_op, 3'd7);
        check({name, "_alu_a_idle"}, alu_a, 0);
    endtask

    task automatic do_cmd(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] hand_res, input logic hand_co);
        int n;
        drive_cmd(name, op, a, b, ci, hand_res, hand_co);
        wait_accept(name, n);
        check({name, "_accept_cycles"}, n, 1);
        run_body(name, op, a, b, ci);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        #3;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_co", rsp_co, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_alu_op", alu_op, 7);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_ci", alu_ci, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        do_cmd("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        do_cmd("adc_ci",    3'd1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0);
        do_cmd("sbb_under", 3'd2, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
        do_cmd("sbb_bin",   3'd2, 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000E, 1'b0);
        do_cmd("xor",       3'd5, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 32'h5A5A_A5A5, 1'b0);
        do_cmd("not",       3'd6, 32'h0000_FFFF, 32'h1234_5678, 1'b1, 32'hFFFF_0000, 1'b0);
        do_cmd("and_ci",    3'd3, 32'hF0F0_F0FF, 32'h3C3C_3CFF, 1'b1, 32'h3030_30FF, 1'b0);
        do_cmd("or",        3'd4, 32'h0F00_0F00, 32'h00F0_00F0, 1'b0, 32'h0FF0_0FF0, 1'b0);
        do_cmd("add_msb",   3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0);
        do_cmd("adc_wrap",  3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        do_cmd("sbb_eq",    3'd2, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0);

        // Back-pressure: hold rsp_ready low while a second command waits.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        do_cmd("bp_first",  3'd0, 32'h0001_00FF, 32'h0000_0001, 1'b0, 32'h0001_0100, 1'b0);
        drive_cmd("bp_second", 3'd4, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_cmd_ready_low", cmd_ready, 0);
            check("bp_rsp_valid_held", rsp_valid, 1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_accept("bp_second", n);
        check("bp_second_accept_cycles", n, 2);
        run_body("bp_second", 3'd4, 32'h8000_0000, 32'h0000_0001, 1'b0);

        do_cmd("clr",       3'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b0);

        // Reset during RUN byte 2 discards the command with no response.
        drive_cmd("rst_mid", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1);
        wait_accept("rst_mid", n);
        check("rst_mid_accept_cycles", n, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_result", rsp_result, 0);
        check("mid_rst_rsp_co", rsp_co, 0);
        check("mid_rst_rsp_zero", rsp_zero, 0);
        check("mid_rst_alu_op", alu_op, 7);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_ci", alu_ci, 0);
        exp_q.delete();
        exp_co_q.delete();
        exp_zero_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < NBYTES + 4; k++) begin
            @(negedge clk);
            check("after_rst_no_rsp", rsp_valid, 0);
        end

        check("drain_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Hard time limit in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
